// File: rtl/cool_arith_pkg.sv
// Shared arithmetic types and helpers for the iterative divider datapath.
package cool_arith_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Counter width for DATA_WIDTH-1 .. 0; at least one bit even for tiny widths.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subtractor_nb.sv
// Ripple-borrow subtractor A-B built from full_adder cells (two's complement add).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module subtractor_nb #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH];
endmodule

// File: rtl/restoring_divider_nb.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | trial subtraction, one quotient bit per cycle
// DONE  | result held until out_ready
module restoring_divider_nb
  import cool_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = clog2(DATA_WIDTH);

  div_state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [W:0]       rem;
  logic [W-1:0]     q;
  logic [W-1:0]     divisor_reg;
  logic [W:0]       trial;
  logic             trial_borrow;
  logic             accept;
  logic             rem_msb_unused;

  assign accept         = in_valid && in_ready;
  assign rem_msb_unused = rem[W];

  subtractor_nb #(.WIDTH(W + 1)) u_sub (
    .a      ({rem[W-1:0], q[W-1]}),
    .b      ({1'b0, divisor_reg}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      divisor_reg <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor_reg <= divisor;
            if (divisor == '0) begin
              q           <= '1;
              rem         <= {1'b0, dividend};
              div_by_zero <= 1'b1;
            end else begin
              q   <= dividend;
              rem <= '0;
              cnt <= CNT_W'(W - 1);
            end
          end
        end
        CALC: begin
          if (!trial_borrow) begin
            rem <= trial;
            q   <= {q[W-2:0], 1'b1};
          end else begin
            rem <= {rem[W-1:0], q[W-1]};
            q   <= {q[W-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: if (out_ready) div_by_zero <= 1'b0;
        default: ;
      endcase
    end
  end

  assign quotient  = q;
  assign remainder = rem[W-1:0];

endmodule

// File: tb/tb_restoring_divider_nb.sv
// Randomized self-checking bench for restoring_divider_nb against a plain / and % model.
module tb_restoring_divider_nb;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_divider_nb #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Waits for out_valid; edges counted from 1 at the accepting edge.
  task automatic wait_out(inout int n);
    while (!out_valid && n < 60) begin
      @(posedge clk); n++; #1;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, n;
    ez   = (b == 0);
    eq   = ez ? '1 : a / b;
    er   = ez ? a : a % b;
    elat = ez ? 1 : W + 1;
    @(negedge clk);
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); n = 1; #1;
    in_valid = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    wait_out(n);
    check("latency", 32'(n), 32'(elat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_busy", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(quotient), 32'(eq));
      check("hold_remainder", 32'(remainder), 32'(er));
      check("hold_dbz", 32'(div_by_zero), 32'(ez));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_ack", 32'(in_ready), 32'd1);
    check("valid_low_after_ack", 32'(out_valid), 32'd0);
    check("dbz_clear", 32'(div_by_zero), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_div(16'd100, 16'd7, 0);
    run_div(16'hFFFF, 16'h0001, 0);
    run_div(16'd5, 16'd9, 0);
    run_div(16'd1234, 16'd0, 2);
    run_div(16'd1000, 16'd10, 5);
    run_div(16'h8000, 16'hFFFF, 1);
    run_div(16'hFFFF, 16'hFFFF, 0);

    // In_valid held high with new operands while a division is in progress.
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'd50; divisor = 16'd6;
    @(posedge clk); n = 1; #1;
    @(negedge clk); dividend = 16'd77; divisor = 16'd3;
    wait_out(n);
    check("busy_latency", 32'(n), 32'(W + 1));
    check("busy_quotient", 32'(quotient), 32'd8);
    check("busy_remainder", 32'(remainder), 32'd2);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("busy_idle", 32'(in_ready), 32'd1);
    @(posedge clk); n = 1; #1;
    in_valid = 1'b0;
    check("busy_accept", 32'(in_ready), 32'd0);
    wait_out(n);
    check("second_latency", 32'(n), 32'(W + 1));
    check("second_quotient", 32'(quotient), 32'd25);
    check("second_remainder", 32'(remainder), 32'd2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("second_idle", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'd60000; divisor = 16'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_div(16'd9, 16'd3, 0);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(1, 15));
        1:       b = W'($urandom_range(1, 255));
        default: b = W'($urandom_range(1, 65535));
      endcase
      run_div(a, b, (i % 10 == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
